keypad_scan: RTL

Matrix keypad scanner for a 4x4 active-low key matrix, the input counterpart to the multiplexed seven-segment display driver. It drives one column low at a time using the same counter-based time-slot scan, samples the row lines, and rejects ghosting from multiple simultaneous keys. Each debounced press becomes a single key code event, which a downstream controller (mode/pattern selection for the cube) takes over a valid/ready handshake.

---
 rtl/keypad_scan.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// Purpose : 4x4 active-low keypad scanner with debounce, ghost rejection and a one-entry key code register.
// Latency : key code appears 2 cycles after the column-3 terminal count of the confirming scan.
// Backpress: single output slot; a press arriving while the slot is full and not being taken is dropped and flagged on key_overrun.
module keypad_scan #(
    parameter int SCAN_BITS      = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_overrun
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_PRESSED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Row synchroniser, divider and column scan
    logic [3:0]           row_meta;
    logic [3:0]           row_sync;
    logic [SCAN_BITS-1:0] div;
    logic                 tc;
    logic [1:0]           col_idx;
    logic [15:0]          snap;
    logic                 scan_done;

    // Scan classification
    logic [4:0]           hit_cnt;
    logic [3:0]           hit_code;
    logic                 scan_single;
    logic                 cand_seen;

    // Debounce FSM
    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cand;
    logic [3:0]           cand_nxt;
    logic [3:0]           cnt;
    logic [3:0]           cnt_nxt;
    logic                 press_evt;

    logic                 xfer;

    // Rows are asynchronous to clk; idle level of a pulled-up row is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign tc = &div;

    // Free-running dwell divider; the column steps on its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            col_idx <= 2'd0;
        end else begin
            div <= div + SCAN_BITS'(1);
            if (tc) begin
                col_idx <= col_idx + 2'd1;
            end
        end
    end

    assign col_n = ~(4'b0001 << col_idx);

    // Rows are taken at the very end of the dwell so the column drive has settled.
    // Each column owns a 4-bit slot, so the snapshot is complete once column 3 lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap      <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= tc && (col_idx == 2'd3);
            if (tc) begin
                snap[{col_idx, 2'b00} +: 4] <= ~row_sync;
            end
        end
    end

    // Count closed keys and remember the code of one of them; only meaningful when exactly one is set.
    always_comb begin
        hit_cnt  = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    assign scan_single = (hit_cnt == 5'd1);
    // A held key stays held even when other keys join it (ghost rows do not cancel it).
    assign cand_seen   = snap[cand];

    // FSM state, candidate and debounce counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; evaluated only on a completed scan.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        if (scan_done) begin
            case (state)
                S_IDLE: begin
                    if (scan_single) begin
                        cand_nxt = hit_code;
                        cnt_nxt  = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nxt = S_PRESSED;
                        end else begin
                            state_nxt = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (scan_single && (hit_code == cand)) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt_nxt >= DEB) begin
                            state_nxt = S_PRESSED;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (!cand_seen) begin
                        cnt_nxt = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (cand_seen) begin
                        state_nxt = S_PRESSED;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt_nxt >= DEB) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM outputs: a press event only on entry to PRESSED from the unpressed side.
    always_comb begin
        press_evt = scan_done && (state_nxt == S_PRESSED) &&
                    ((state == S_IDLE) || (state == S_CONFIRM));
        key_held  = (state == S_PRESSED) || (state == S_RELEASE);
    end

    assign xfer = key_valid && key_ready;

    // One-entry code register; a transfer in the same cycle frees the slot for a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (press_evt && (!key_valid || key_ready)) begin
                key_valid <= 1'b1;
                key_code  <= cand_nxt;
            end else begin
                if (xfer) begin
                    key_valid <= 1'b0;
                end
                if (press_evt) begin
                    key_overrun <= 1'b1;
                end
            end
        end
    end

    // Exactly one column is driven low at a time.
    a_col_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(~col_n));

    // A pending code holds until it is taken.
    a_code_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (key_valid && !key_ready) |=> (key_valid && $stable(key_code)));

endmodule
